// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and constants for the round-robin bus arbiter.
//                arb_state_t - arbiter FSM states
//                MAX_MASTERS - upper bound on the number of masters supported
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE        = 2'd0,
        ARB_GRANT       = 2'd1,
        ARB_GRANT_SPLIT = 2'd2
    } arb_state_t;

    localparam int MAX_MASTERS = 8;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_pick
//  Description : Combinational round-robin picker. Searches the request
//                vector (minus the exclude mask) starting at last_owner+1,
//                wrapping from N_MASTERS-1 to 0. last_owner itself is
//                searched last.
//  Ports       : req        [N_MASTERS-1:0] in  request vector
//                last_owner [IDW-1:0]       in  most recently granted master
//                exclude    [N_MASTERS-1:0] in  requests to ignore this cycle
//                pick       [N_MASTERS-1:0] out one-hot winner
//                pick_idx   [IDW-1:0]       out winner index
//                pick_valid                 out a winner exists
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
    parameter int N_MASTERS = 2,
    parameter int IDW       = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IDW-1:0]       last_owner,
    input  logic [N_MASTERS-1:0] exclude,
    output logic [N_MASTERS-1:0] pick,
    output logic [IDW-1:0]       pick_idx,
    output logic                 pick_valid
);

    logic [N_MASTERS-1:0] w_cand;

    assign w_cand = req & ~exclude;

    // Walk the ring from the farthest position to the nearest one; each hit
    // overwrites the previous, so the nearest candidate after last_owner wins.
    always_comb begin
        pick       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int i = N_MASTERS; i >= 1; i--) begin
            if (w_cand[(int'(last_owner) + i) % N_MASTERS]) begin
                pick       = '0;
                pick[(int'(last_owner) + i) % N_MASTERS] = 1'b1;
                pick_idx   = IDW'((int'(last_owner) + i) % N_MASTERS);
                pick_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_bus_arbiter
//  Description : N-master bus arbiter with a split-transaction channel,
//                round-robin fairness, back-to-back handoff and optional
//                bounded grant tenure. N_MASTERS legal range is 2..8.
//  Ports       : clk                           clock, rising edge
//                rst                           synchronous active-high reset
//                req         [N_MASTERS-1:0]   per-master level requests
//                req_split                     split-resume request
//                grant       [N_MASTERS-1:0]   one-hot master grant (reg)
//                grant_split                   split-channel grant (reg)
//                owner_id    [IDW-1:0]         index of granted master (reg)
//                bus_busy                      any grant active (reg)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter  int N_MASTERS  = 2,
    parameter  int MAX_TENURE = 0,
    localparam int IDW        = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 req_split,
    output logic [N_MASTERS-1:0] grant,
    output logic                 grant_split,
    output logic [IDW-1:0]       owner_id,
    output logic                 bus_busy
);

    arb_state_t           r_state;
    logic [IDW-1:0]       r_last_owner;

    logic [N_MASTERS-1:0] w_exclude;
    logic [N_MASTERS-1:0] w_pick;
    logic [IDW-1:0]       w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_release;
    logic                 w_preempt;
    logic                 w_decide;
    logic                 w_go_split;
    logic                 w_go_master;

    // While a master holds the bus, the registered one-hot grant is exactly
    // the owner mask, so it doubles as the exclude mask for re-arbitration.
    assign w_exclude = (r_state == ARB_GRANT) ? grant : '0;
    assign w_release = (r_state == ARB_GRANT) && ((req & grant) == '0);

    assign w_decide    = (r_state == ARB_IDLE)
                       || ((r_state == ARB_GRANT) && (w_release || w_preempt))
                       || ((r_state == ARB_GRANT_SPLIT) && !req_split);
    // req_split is necessarily low when leaving ARB_GRANT_SPLIT, so it only
    // wins from idle or from a master release/preemption.
    assign w_go_split  = w_decide && req_split;
    assign w_go_master = w_decide && !req_split && w_pick_valid;

    rr_priority_pick #(
        .N_MASTERS (N_MASTERS),
        .IDW       (IDW)
    ) u_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .exclude    (w_exclude),
        .pick       (w_pick),
        .pick_idx   (w_pick_idx),
        .pick_valid (w_pick_valid)
    );

    generate
        if (MAX_TENURE > 0) begin : g_tenure
            localparam int TW = $clog2(MAX_TENURE + 1);

            logic [TW-1:0] r_tenure;
            logic          w_others;

            assign w_others = ((req & ~grant) != '0) || req_split;

            // Counter sits at MAX_TENURE-1 from the owner's last allowed
            // cycle onward, so a requester arriving late still triggers the
            // handoff on the next edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tenure <= '0;
                end else if (w_go_master) begin
                    r_tenure <= '0;
                end else if ((r_state == ARB_GRANT) &&
                             (r_tenure != TW'(MAX_TENURE - 1))) begin
                    r_tenure <= r_tenure + 1'b1;
                end
            end

            assign w_preempt = (r_state == ARB_GRANT)
                             && (r_tenure == TW'(MAX_TENURE - 1))
                             && w_others;
        end else begin : g_no_tenure
            assign w_preempt = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_owner <= IDW'(N_MASTERS - 1);
            grant        <= '0;
            grant_split  <= 1'b0;
            owner_id     <= '0;
            bus_busy     <= 1'b0;
        end else if (w_decide) begin
            if (w_go_split) begin
                r_state     <= ARB_GRANT_SPLIT;
                grant       <= '0;
                grant_split <= 1'b1;
                bus_busy    <= 1'b1;
            end else if (w_go_master) begin
                r_state      <= ARB_GRANT;
                grant        <= w_pick;
                grant_split  <= 1'b0;
                owner_id     <= w_pick_idx;
                r_last_owner <= w_pick_idx;
                bus_busy     <= 1'b1;
            end else begin
                r_state     <= ARB_IDLE;
                grant       <= '0;
                grant_split <= 1'b0;
                bus_busy    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_bus_arbiter
//  Description : Self-checking bench for rr_bus_arbiter (N_MASTERS=4,
//                MAX_TENURE=8). Directed steps push the expected next-cycle
//                outputs into a scoreboard queue; they are popped and
//                compared one cycle later. A negedge monitor checks grant
//                exclusivity and bus_busy every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_bus_arbiter;

    localparam int N  = 4;
    localparam int MT = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         req_split = 1'b0;
    logic [N-1:0] grant;
    logic         grant_split;
    logic [1:0]   owner_id;
    logic         bus_busy;

    typedef struct packed {
        logic [3:0] g;
        logic       s;
        logic [1:0] o;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(
        .N_MASTERS  (N),
        .MAX_TENURE (MT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_split   (req_split),
        .grant       (grant),
        .grant_split (grant_split),
        .owner_id    (owner_id),
        .bus_busy    (bus_busy)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, record what the outputs must be after the
    // next edge, then pop and compare once that edge has passed.
    task automatic step(input string tag, input logic [3:0] r, input logic s,
                        input logic [3:0] eg, input logic es, input logic [1:0] eo);
        exp_t e;
        req       = r;
        req_split = s;
        e.g = eg;
        e.s = es;
        e.o = eo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".grant"},       8'(grant),       8'(e.g));
        check({tag, ".grant_split"}, 8'(grant_split), 8'(e.s));
        check({tag, ".bus_busy"},    8'(bus_busy),    8'((|e.g) | e.s));
        if (e.g != 4'b0000)
            check({tag, ".owner_id"}, 8'(owner_id), 8'(e.o));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert ($onehot0({grant, grant_split})) else begin
                errors++;
                $error("FAIL onehot: observed %b expected at most one-hot", {grant, grant_split});
            end
            checks++;
            assert (bus_busy === ((|grant) | grant_split)) else begin
                errors++;
                $error("FAIL busy: observed %b expected %b", bus_busy, (|grant) | grant_split);
            end
        end
    end

    initial begin
        // Reset holds everything low even with requests present
        rst = 1'b1;
        step("reset0", 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0);
        mon_en = 1'b1;
        step("reset1", 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0);
        rst = 1'b0;

        // Rotation with all masters requesting; each owner drops for a cycle
        step("rot0",  4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("rot1",  4'b1110, 1'b0, 4'b0010, 1'b0, 2'd1);
        step("rot2",  4'b1101, 1'b0, 4'b0100, 1'b0, 2'd2);
        step("rot3",  4'b1011, 1'b0, 4'b1000, 1'b0, 2'd3);
        step("rot4",  4'b0111, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("rot_hold", 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("rot_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);

        // Split beats a master rising in the same idle cycle
        step("sp_first", 4'b0100, 1'b1, 4'b0000, 1'b1, 2'd0);
        step("sp_hold",  4'b0100, 1'b1, 4'b0000, 1'b1, 2'd0);
        step("sp_after", 4'b0100, 1'b0, 4'b0100, 1'b0, 2'd2);
        step("sp_idle",  4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);

        // Tenure: grant[0] lasts exactly MT cycles once req[1] is waiting
        step("ten_start", 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0);
        for (int i = 0; i < MT - 1; i++)
            step("ten_hold", 4'b0011, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("ten_preempt", 4'b0011, 1'b0, 4'b0010, 1'b0, 2'd1);
        step("ten_back",    4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0);
        // Lone requester keeps the bus indefinitely
        for (int i = 0; i < 50; i++)
            step("ten_alone", 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("ten_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);

        // Split request during grant[3] waits for release
        step("spg_grant", 4'b1000, 1'b0, 4'b1000, 1'b0, 2'd3);
        for (int i = 0; i < 3; i++)
            step("spg_nopre", 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd3);
        step("spg_split",  4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0);
        step("spg_shold",  4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0);
        step("spg_resume", 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0);
        step("spg_idle",   4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);

        // Mid-grant reset clears outputs and restarts the pointer
        step("rst_grant", 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd1);
        rst = 1'b1;
        step("rst_clear", 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0);
        rst = 1'b0;
        step("rst_first", 4'b0110, 1'b0, 4'b0010, 1'b0, 2'd1);
        step("rst_next",  4'b0100, 1'b0, 4'b0100, 1'b0, 2'd2);
        step("rst_idle",  4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
